// File: rtl/arm_fetch.sv
// ARM instruction fetch: owns fetch PC, single-outstanding word reads,
// prefetch FIFO towards the decoder, redirect flush and halt.
module arm_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DROP
  } state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [AW:0] count_q, count_d;
  logic [AW:0] cnt_nxt;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0] data_q [DEPTH];
  logic [31:0] pc_q [DEPTH];

  logic        ack, pop, push, issue_ok;
  logic [31:0] tgt;

  always_comb begin
    ack      = mem_req_q & mem_ack;
    pop      = (count_q != '0) & inst_ready;
    push     = ack & (state_q == BUSY) & ~redirect;
    tgt      = {redirect_pc[31:2], 2'b00};
    cnt_nxt  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    issue_ok = ~halt & (cnt_nxt < DEPTH_C);

    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = cnt_nxt;

    if (redirect) begin
      count_d    = '0;
      fetch_pc_d = tgt;
      // A request still in flight must finish before the target goes out
      if (state_q != IDLE && !ack) begin
        state_d = DROP;
      end else if (!halt) begin
        state_d    = BUSY;
        mem_addr_d = tgt;
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (push) fetch_pc_d = fetch_pc_q + 32'd4;
      unique case (state_q)
        IDLE: begin
          if (issue_ok) begin
            state_d    = BUSY;
            mem_addr_d = fetch_pc_q;
          end
        end
        BUSY, DROP: begin
          if (ack) begin
            if (issue_ok) begin
              state_d    = BUSY;
              mem_addr_d = fetch_pc_d;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    mem_req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= mem_rdata;
        pc_q[wr_ptr_q]   <= fetch_pc_q;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst       = data_q[rd_ptr_q];
  assign inst_pc    = pc_q[rd_ptr_q];
  assign inst_valid = (count_q != '0);

endmodule

// File: tb/tb_arm_fetch.sv
// Bench for arm_fetch: directed vector table, wrap sequence and
// randomized run against a queue-based reference model.
module tb_arm_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] WPC   = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst, mem_ack, inst_ready, redirect, halt;
  logic [31:0] redirect_pc;
  logic        mem_req, inst_valid;
  logic [31:0] mem_addr, mem_rdata, inst, inst_pc;

  logic        w_rst, w_ack, w_rdy, w_redir, w_halt;
  logic [31:0] w_rpc;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc;

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  assign mem_rdata = mem_ack ? fdat(mem_addr) : 32'hDEAD_BEEF;
  assign w_rdata   = w_ack ? fdat(w_addr) : 32'hDEAD_BEEF;

  arm_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt)
  );

  arm_fetch #(.RESET_PC(WPC), .DEPTH(4)) u_wrap (
    .clk(clk), .rst(w_rst),
    .mem_req(w_req), .mem_addr(w_addr),
    .mem_ack(w_ack), .mem_rdata(w_rdata),
    .inst(w_inst), .inst_pc(w_pc),
    .inst_valid(w_valid), .inst_ready(w_rdy),
    .redirect(w_redir), .redirect_pc(w_rpc),
    .halt(w_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, ack, rdy, redir;
    logic [31:0] rpc;
    logic        halt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[$];

  task automatic addv(input logic r, input logic a, input logic y,
                      input logic d, input logic [31:0] p,
                      input logic h, input logic er,
                      input logic [31:0] ea, input logic ev,
                      input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.ack = a; v.rdy = y; v.redir = d; v.rpc = p;
    v.halt = h; v.e_req = er; v.e_addr = ea;
    v.e_valid = ev; v.e_pc = ep;
    vt.push_back(v);
  endtask

  logic [31:0] q[$];
  logic [31:0] m_fetch, m_addr;
  logic        m_req, m_stale, done, popm;
  logic [31:0] wexp_addr [4];
  logic [31:0] wexp_pc [4];

  initial begin
    rst = 1'b1; mem_ack = 1'b0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    w_rst = 1'b1; w_ack = 1'b1; w_rdy = 1'b1;
    w_redir = 1'b0; w_rpc = '0; w_halt = 1'b0;

    // rst ack rdy redir rpc halt | req addr valid pc
    addv(1,1,1,0,32'h0,0, 0,32'h000,0,32'h0);
    addv(1,1,1,0,32'h0,0, 0,32'h000,0,32'h0);
    addv(0,1,1,0,32'h0,0, 1,32'h000,0,32'h0);
    addv(0,1,1,0,32'h0,0, 1,32'h004,1,32'h000);
    addv(0,1,1,0,32'h0,0, 1,32'h008,1,32'h004);
    addv(0,1,1,0,32'h0,0, 1,32'h00C,1,32'h008);
    addv(0,1,0,0,32'h0,0, 0,32'h00C,1,32'h008);
    addv(0,1,0,0,32'h0,0, 0,32'h00C,1,32'h008);
    addv(0,1,1,0,32'h0,0, 1,32'h010,1,32'h00C);
    addv(0,0,0,0,32'h0,0, 1,32'h010,1,32'h00C);
    addv(0,0,0,1,32'h100,0, 1,32'h010,0,32'h0);
    addv(0,0,0,0,32'h0,0, 1,32'h010,0,32'h0);
    addv(0,0,0,0,32'h0,0, 1,32'h010,0,32'h0);
    addv(0,1,0,0,32'h0,0, 1,32'h100,0,32'h0);
    addv(0,0,0,0,32'h0,0, 1,32'h100,0,32'h0);
    addv(0,1,0,0,32'h0,0, 1,32'h104,1,32'h100);
    addv(0,1,1,1,32'h203,0, 1,32'h200,0,32'h0);
    addv(0,1,1,0,32'h0,0, 1,32'h204,1,32'h200);
    addv(0,0,0,0,32'h0,1, 1,32'h204,1,32'h200);
    addv(0,1,0,0,32'h0,1, 0,32'h204,1,32'h200);
    addv(0,0,1,0,32'h0,1, 0,32'h204,1,32'h204);
    addv(0,0,1,0,32'h0,1, 0,32'h204,0,32'h0);
    addv(0,0,1,0,32'h0,0, 1,32'h208,0,32'h0);
    addv(0,1,1,0,32'h0,0, 1,32'h20C,1,32'h208);
    addv(0,0,0,1,32'h300,0, 1,32'h20C,0,32'h0);
    addv(0,0,0,1,32'h400,0, 1,32'h20C,0,32'h0);
    addv(0,1,0,0,32'h0,0, 1,32'h400,0,32'h0);
    addv(0,1,1,0,32'h0,0, 1,32'h404,1,32'h400);
    addv(1,0,0,0,32'h0,0, 0,32'h000,0,32'h0);
    addv(0,1,1,0,32'h0,0, 1,32'h000,0,32'h0);
    addv(0,1,1,0,32'h0,0, 1,32'h004,1,32'h000);

    foreach (vt[i]) begin
      rst = vt[i].rst; mem_ack = vt[i].ack;
      inst_ready = vt[i].rdy; redirect = vt[i].redir;
      redirect_pc = vt[i].rpc; halt = vt[i].halt;
      @(posedge clk); #1;
      chk($sformatf("vec%0d req", i), 32'(mem_req), 32'(vt[i].e_req));
      if (vt[i].e_req || vt[i].rst)
        chk($sformatf("vec%0d addr", i), mem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d valid", i), 32'(inst_valid),
          32'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d pc", i), inst_pc, vt[i].e_pc);
        chk($sformatf("vec%0d inst", i), inst, fdat(vt[i].e_pc));
      end
      if (vt[i].rst && i == 0)
        chk("reset inst", inst, 32'h0);
    end

    // Wrap of the fetch PC across the top of the address space
    wexp_addr[0] = 32'hFFFF_FFF8; wexp_pc[0] = 32'h0;
    wexp_addr[1] = 32'hFFFF_FFFC; wexp_pc[1] = 32'hFFFF_FFF8;
    wexp_addr[2] = 32'h0000_0000; wexp_pc[2] = 32'hFFFF_FFFC;
    wexp_addr[3] = 32'h0000_0004; wexp_pc[3] = 32'h0000_0000;
    @(posedge clk); #1;
    chk("wrap reset req", 32'(w_req), 32'h0);
    chk("wrap reset addr", w_addr, WPC);
    w_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("wrap%0d addr", i), w_addr, wexp_addr[i]);
      chk($sformatf("wrap%0d valid", i), 32'(w_valid), 32'(i != 0));
      if (i != 0) begin
        chk($sformatf("wrap%0d pc", i), w_pc, wexp_pc[i]);
        chk($sformatf("wrap%0d inst", i), w_inst, fdat(wexp_pc[i]));
      end
    end
    w_rst = 1'b1;

    // Randomized run against the queue model
    halt = 1'b0;
    m_req = 1'b0; m_stale = 1'b0; m_fetch = RPC; m_addr = RPC;
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 0) || ($urandom_range(0, 299) == 0);
      mem_ack = ($urandom_range(0, 9) < 6);
      inst_ready = ($urandom_range(0, 9) < 6);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 9) == 0) halt = ~halt;

      if (rst) begin
        q.delete();
        m_fetch = RPC; m_addr = RPC;
        m_req = 1'b0; m_stale = 1'b0;
      end else begin
        done = m_req && mem_ack;
        popm = (q.size() > 0) && inst_ready;
        if (redirect) begin
          q.delete();
          m_fetch = {redirect_pc[31:2], 2'b00};
          if (m_req && !done) begin
            m_stale = 1'b1;
          end else begin
            m_stale = 1'b0;
            m_req = !halt;
            if (!halt) m_addr = m_fetch;
          end
        end else begin
          if (popm) void'(q.pop_front());
          if (done && !m_stale) begin
            q.push_back(m_addr);
            m_fetch = m_addr + 32'd4;
          end
          if (done) m_stale = 1'b0;
          if (!m_req || done) begin
            m_req = !halt && (q.size() < DEPTH);
            if (m_req) m_addr = m_fetch;
          end
        end
      end

      @(posedge clk); #1;
      chk($sformatf("rnd%0d req", c), 32'(mem_req), 32'(m_req));
      if (m_req || rst)
        chk($sformatf("rnd%0d addr", c), mem_addr, m_addr);
      chk($sformatf("rnd%0d valid", c), 32'(inst_valid),
          32'(q.size() > 0));
      if (q.size() > 0) begin
        chk($sformatf("rnd%0d pc", c), inst_pc, q[0]);
        chk($sformatf("rnd%0d inst", c), inst, fdat(q[0]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arm_fetch.md
# arm_fetch

Instruction fetch unit for the ARM core: owns the fetch PC, issues word reads to instruction memory over a req/ack handshake, buffers returned words in a small prefetch FIFO, and hands them to the instruction decoder through a valid/ready interface. It sits between instruction memory and the decoder. It takes branch and PC-write redirects and the halt indication back from the decode/execute side.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch FIFO entries; a power of 2, at least 2.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- mem_req, output, 1, read request; registered.
- mem_addr, output, 32, word address of the request; registered; bits [1:0] always 0.
- mem_ack, input, 1, the transfer completes on an edge where mem_req && mem_ack.
- mem_rdata, input, 32, instruction word; valid only when mem_ack is high.
- inst, output, 32, FIFO head instruction to the decoder.
- inst_pc, output, 32, address of inst.
- inst_valid, output, 1, FIFO non-empty.
- inst_ready, input, 1, decoder accepts; a pop occurs on an edge where inst_valid && inst_ready.
- redirect, input, 1, PC write (branch or pc_we); single-cycle pulse or level.
- redirect_pc, input, 32, new fetch address; bits [1:0] are ignored (forced to 0).
- halt, input, 1, level; stops the issue of new requests (SWI).

## Operation
- FSM states:
  - IDLE: no outstanding request, mem_req=0.
  - BUSY: one request outstanding, mem_req=1.
  - DROP: a stale request is outstanding, mem_req=1, and its data will be discarded.
- At most one outstanding request. mem_req and mem_addr hold stable until ack; a request is never withdrawn.
- Issue rule: a new request may be issued at an edge only if fifo_count_after_edge + 1 <= DEPTH, halt=0 and rst=0.
  - It may be issued from IDLE.
  - It may be issued from BUSY/DROP on the ack edge, giving back-to-back requests with mem_req staying high.
- Ack in BUSY: push {fetch_pc, mem_rdata}, then fetch_pc += 4 (wraps 32'hFFFF_FFFC to 0).
  - Go to BUSY with mem_addr=new fetch_pc if the issue rule holds, else IDLE.
- Ack in DROP: discard the data. Issue at the redirected fetch_pc if the issue rule holds (go to BUSY), else IDLE.
- Push and pop on the same edge: count is unchanged and both pointers advance. By construction, no push ever occurs into a full FIFO.
- Redirect has the highest priority. On an edge with redirect=1:
  - FIFO is flushed (count=0, pointers=0) and any simultaneous pop or push is discarded.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - Outstanding request without ack this edge: go to DROP.
  - Ack on this same edge, or IDLE: the data is discarded and a request to the new fetch_pc is issued immediately (BUSY), subject to halt.
  - Redirect while in DROP: the target is updated and the state stays DROP.
- halt=1 blocks new issues only:
  - An outstanding request still completes and pushes (BUSY), or is discarded (DROP).
  - The FIFO keeps draining to the decoder.
  - When halt drops, issue resumes at fetch_pc.
- Reset mid-transfer: all state returns to reset values. A stale ack arriving after reset is ignored because mem_req=0.

## Timing
- Reset values:
  - mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC.
  - inst_valid=0, inst=0, inst_pc=0 (FIFO storage cleared).
  - FSM=IDLE.
- First request: mem_req=1 with mem_addr=RESET_PC in the first cycle after rst deasserts.
- Latency: ack at edge N gives inst_valid=1 with the data in cycle N+1.
- Zero-wait memory (mem_ack tied 1) with inst_ready=1 sustains 1 instruction/cycle, with consecutive addresses.
- Redirect at edge N:
  - inst_valid=0 in cycle N+1.
  - mem_addr=target in cycle N+1 if no stale request is outstanding. Otherwise mem_addr=target in the cycle after the stale ack.
- inst, inst_pc and inst_valid depend only on registered state (no combinational path from inst_ready).

## Test plan
- Reset then zero-wait memory returning addr as data, inst_ready=1:
  - mem_addr 0,4,8,... in consecutive cycles.
  - inst_valid from cycle 2 with inst_pc 0,4,8, one per cycle.
- inst_ready=0, memory acks every cycle, DEPTH=2:
  - exactly 2 entries fill (inst_pc 0 then 4) and mem_req falls to 0.
  - Raising inst_ready pops 0 and re-issues 8 on the same edge as the pop.
- Redirect to 32'h100 while a request to 8 waits 3 cycles for ack:
  - mem_addr stays 8 until ack and data for 8 never appears.
  - next mem_addr=32'h100, and the next inst_pc=32'h100.
- Redirect to 32'h203 coincident with ack and pop: FIFO empty next cycle, mem_addr=32'h200.
- halt=1 with request outstanding:
  - the ack pushes, then mem_req=0 while the FIFO drains.
  - halt=0 resumes at the next sequential address.
- RESET_PC=32'hFFFF_FFF8: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
